// File: rtl/fpu_arbiter.sv
// Round-robin share of one combinational fpu among NUM_REQ requesters; FPU_LAT cycles accept-to-response, optional sticky flags via FPU_ARB_STICKY_FLAGS_EN.
// Response holds in RESP until rsp_ready[grant]; no request is accepted outside IDLE, so pending requesters simply wait.
module fpu (
  input  logic [31:0] opd1,
  input  logic [31:0] opd2,
  input  logic [1:0]  op,
  output logic [31:0] res,
  output logic [3:0]  flags
);
  logic        sa, sb, s_big, sgn, a_big, nan_in, is_zero;
  logic [7:0]  ea, eb, e_big, diff;
  logic [23:0] ma, mb, m_big, m_sml;
  logic [24:0] sum;
  logic [4:0]  msb;
  logic [47:0] prod;
  logic [9:0]  exp_w;
  logic [22:0] mant;

  // op: 00 add, 01 sub, 10 mul, 11 abs(opd1); truncating, denormals flushed, Inf/NaN inputs give qNaN
  always_comb begin
    sa     = opd1[31];
    sb     = opd2[31] ^ (op == 2'b01);
    ea     = opd1[30:23];
    eb     = opd2[30:23];
    ma     = (ea != 8'd0) ? {1'b1, opd1[22:0]} : 24'd0;
    mb     = (eb != 8'd0) ? {1'b1, opd2[22:0]} : 24'd0;
    nan_in = (ea == 8'hFF) || (eb == 8'hFF);
    a_big  = opd1[30:0] >= opd2[30:0];
    s_big  = a_big ? sa : sb;
    e_big  = a_big ? ea : eb;
    m_big  = a_big ? ma : mb;
    m_sml  = a_big ? mb : ma;
    diff   = a_big ? ea - eb : eb - ea;
    sum    = (sa == sb) ? {1'b0, m_big} + {1'b0, m_sml >> diff}
                        : {1'b0, m_big} - {1'b0, m_sml >> diff};
    msb = 5'd0;
    for (int k = 0; k < 25; k++)
      if (sum[k]) msb = 5'(k);
    prod = {24'd0, ma} * {24'd0, mb};
    case (op)
      2'b10: begin
        is_zero = (ma == 24'd0) || (mb == 24'd0);
        sgn     = sa ^ sb;
        exp_w   = {2'b00, ea} + {2'b00, eb} - 10'd127 + {9'd0, prod[47]};
        mant    = prod[47] ? 23'(prod >> 24) : 23'(prod >> 23);
      end
      2'b11: begin
        is_zero = (ma == 24'd0);
        sgn     = 1'b0;
        exp_w   = {2'b00, ea};
        mant    = opd1[22:0];
      end
      default: begin
        is_zero = (sum == 25'd0);
        sgn     = s_big;
        exp_w   = {2'b00, e_big} + {5'd0, msb} - 10'd23;
        mant    = 23'((sum << (5'd24 - msb)) >> 1);
      end
    endcase
    if (nan_in) begin
      res = 32'h7FC0_0000; flags = 4'b0010;
    end else if (is_zero) begin
      res = 32'd0;         flags = 4'b0001;
    end else if (exp_w[9] || exp_w == 10'd0) begin
      res = {sgn, 31'd0};  flags = 4'b0101;
    end else if (exp_w >= 10'd255) begin
      res = {sgn, 8'hFF, 23'd0}; flags = 4'b1000;
    end else begin
      res = {sgn, exp_w[7:0], mant}; flags = 4'b0000;
    end
  end
endmodule

module fpu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_opd1,
  input  logic [NUM_REQ*32-1:0] req_opd2,
  input  logic [NUM_REQ*2-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [31:0]          rsp_res,
  output logic [3:0]           rsp_flags,
`ifdef FPU_ARB_STICKY_FLAGS_EN
  output logic                 busy,
  input  logic                 clr_sticky,
  output logic [NUM_REQ*4-1:0] sticky_flags
`else
  output logic                 busy
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr, grant, win_idx, cand;
  logic          win_vld;
  logic [CW-1:0] cnt;
  logic [31:0]   opd1_q, opd2_q, fpu_res;
  logic [1:0]    op_q;
  logic [3:0]    fpu_flags;

  fpu u_fpu (
    .opd1  (opd1_q),
    .opd2  (opd2_q),
    .op    (op_q),
    .res   (fpu_res),
    .flags (fpu_flags)
  );

  // Scan downward so the requester closest to ptr is the last to overwrite
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst_n && win_vld) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      cnt       <= '0;
      opd1_q    <= '0;
      opd2_q    <= '0;
      op_q      <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          opd1_q <= req_opd1[32*win_idx +: 32];
          opd2_q <= req_opd2[32*win_idx +: 32];
          op_q   <= req_op[2*win_idx +: 2];
          grant  <= win_idx;
          cnt    <= CW'(FPU_LAT - 1);
          ptr    <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          busy   <= 1'b1;
          state  <= EVAL;
        end
        EVAL: if (cnt == '0) begin
          rsp_res   <= fpu_res;
          rsp_flags <= fpu_flags;
          rsp_valid <= NUM_REQ'(1) << grant;
          state     <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready[grant]) begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPU_ARB_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (clr_sticky) begin
      sticky_flags <= '0;
    end else if (state == RESP && rsp_ready[grant]) begin
      sticky_flags[4*grant +: 4] <= sticky_flags[4*grant +: 4] | rsp_flags;
    end
  end
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: directed steps plus randomized operations against a real-arithmetic reference.
module tb_fpu_arbiter;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_opd1, req_opd2;
  logic [N*2-1:0]  req_op;
  logic [31:0]     rsp_res;
  logic [3:0]      rsp_flags;
  logic            busy;
`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic            clr_sticky;
  logic [N*4-1:0]  sticky_flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.NUM_REQ(N), .FPU_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opd1     (req_opd1),
    .req_opd2     (req_opd2),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_flags    (rsp_flags),
`ifdef FPU_ARB_STICKY_FLAGS_EN
    .busy         (busy),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags)
`else
    .busy         (busy)
`endif
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real v;
    if (x[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    return x[31] ? -v : v;
  endfunction

  // Exact for the operand ranges used here, so rounding mode never matters
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       output logic [31:0] res, output logic [3:0] flags);
    real va, vb, r;
    va = f2r(a);
    vb = f2r(b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      res = 32'h7FC0_0000; flags = 4'b0010;
      return;
    end
    case (op)
      2'd0:    r = va + vb;
      2'd1:    r = va - vb;
      2'd2:    r = va * vb;
      default: r = (va < 0.0) ? -va : va;
    endcase
    res   = r2f(r);
    flags = (r == 0.0) ? 4'b0001 : 4'b0000;
  endtask

  function automatic logic [31:0] gen_opd();
    real v;
    if ($urandom_range(7) == 0) return 32'd0;
    v = real'($urandom_range(255, 1)) * pow2(int'($urandom_range(8)) - 4);
    if ($urandom_range(1) == 1) v = -v;
    return r2f(v);
  endfunction

  // One isolated operation from requester idx; entered and left at #1 after a rising edge in IDLE
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input int stall, input logic clr);
    logic [31:0] er;
    logic [3:0]  ef;
    logic [N-1:0] oh;
    int cyc;
    model(a, b, op, er, ef);
    oh = N'(1) << idx;
    req_valid = oh;
    req_opd1[32*idx +: 32] = a;
    req_opd2[32*idx +: 32] = b;
    req_op[2*idx +: 2]     = op;
    #1;
    chk("req_ready_grant", req_ready, oh);
    @(posedge clk); #1;
    req_valid = '0;
    req_opd1  = {$urandom, $urandom, $urandom, $urandom};
    req_opd2  = {$urandom, $urandom, $urandom, $urandom};
    req_op    = 8'($urandom);
    chk("busy_after_accept", busy, 1'b1);
    cyc = 0;
    while (rsp_valid == '0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("accept_to_rsp_latency", cyc, LAT);
    chk("rsp_valid_onehot", rsp_valid, oh);
    chk("rsp_res", rsp_res, er);
    chk("rsp_flags", rsp_flags, ef);
    if (stall > 0) begin
      req_valid = ~oh;
      rsp_ready = ~oh;
      repeat (stall) begin
        @(posedge clk); #1;
        chk("stall_rsp_valid", rsp_valid, oh);
        chk("stall_rsp_res", rsp_res, er);
        chk("stall_req_ready", req_ready, 0);
      end
      req_valid = '0;
    end
    rsp_ready = oh;
`ifdef FPU_ARB_STICKY_FLAGS_EN
    clr_sticky = clr;
`endif
    @(posedge clk); #1;
    rsp_ready = '0;
`ifdef FPU_ARB_STICKY_FLAGS_EN
    clr_sticky = 1'b0;
`endif
    chk("idle_after_handshake", {busy, rsp_valid}, 0);
  endtask

  initial begin
    logic [31:0] ra[N];
    logic [3:0]  rf[N];
    int order[6];
    int ng, last, t, ri, w;

    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_opd1 = '0; req_opd2 = '0; req_op = '0;
`ifdef FPU_ARB_STICKY_FLAGS_EN
    clr_sticky = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("reset_outputs_zero", {req_ready, rsp_valid, rsp_res, rsp_flags, busy}, 0);
      @(posedge clk);
    end
    #1;

    do_op(2, 32'h3F80_0000, 32'h4000_0000, 2'b00, 0, 1'b0);
    do_op(1, gen_opd(), gen_opd(), 2'b10, 5, 1'b0);
    do_op(3, 32'h7FC0_0000, 32'h3F80_0000, 2'b00, 0, 1'b0);
    do_op(0, 32'h4040_0000, 32'h4040_0000, 2'b01, 1, 1'b0);

    for (int i = 0; i < 24; i++)
      do_op(int'($urandom_range(N - 1)), gen_opd(), gen_opd(), 2'($urandom_range(3)),
            int'($urandom_range(3)), 1'b0);

    // Requester 3 last leaves the pointer at 0 for the rotation check
    do_op(3, gen_opd(), gen_opd(), 2'b00, 0, 1'b0);
    order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) begin
      logic [31:0] a, b;
      logic [1:0]  op;
      a = gen_opd(); b = gen_opd(); op = 2'($urandom_range(3));
      req_opd1[32*i +: 32] = a;
      req_opd2[32*i +: 32] = b;
      req_op[2*i +: 2]     = op;
      model(a, b, op, ra[i], rf[i]);
    end
    req_valid = '1;
    rsp_ready = '1;
    #1;
    ng = 0; last = 0; t = 0;
    while (ng < 6 && t < 100) begin
      if (rsp_valid != '0) begin
        ri = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) ri = i;
        if (ng > 0) chk("rot_rsp_owner", rsp_valid, N'(1) << order[ng-1]);
        chk("rot_rsp_res", rsp_res, ra[ri]);
        chk("rot_rsp_flags", rsp_flags, rf[ri]);
      end
      if (req_ready != '0) begin
        chk("rot_grant_order", req_ready, N'(1) << order[ng]);
        if (ng > 0) chk("rot_grant_gap", t - last, LAT + 2);
        last = t;
        ng++;
      end
      @(posedge clk); #1;
      t++;
    end
    if (ng < 6) chk("rot_grant_count", ng, 6);
    req_valid = '0;
    w = 0;
    while (busy && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rot_drain_idle", busy, 1'b0);
    rsp_ready = '0;

    // Pointer ends at 2; one more grant to requester 2 moves it to 3 before the reset
    do_op(2, 32'h3F80_0000, 32'h4000_0000, 2'b00, 0, 1'b0);
    req_valid = 4'b0100;
    req_opd1[64 +: 32] = 32'h3F80_0000;
    req_opd2[64 +: 32] = 32'h3F80_0000;
    req_op[4 +: 2]     = 2'b00;
    @(posedge clk); #1;
    chk("pre_reset_eval_busy", busy, 1'b1);
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {req_ready, rsp_valid, rsp_res, rsp_flags, busy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_first_winner", req_ready, 4'b0001);
    rsp_ready = '1;
    @(posedge clk); #1;
    req_valid = '0;
    w = 0;
    while (rsp_valid == '0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("post_reset_rsp_owner", rsp_valid, 4'b0001);
    @(posedge clk); #1;
    rsp_ready = '0;
    chk("post_reset_idle", busy, 1'b0);

`ifdef FPU_ARB_STICKY_FLAGS_EN
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("sticky_cleared", sticky_flags, 0);
    do_op(1, 32'h7FC0_0000, 32'h0000_0000, 2'b10, 0, 1'b0);
    chk("sticky_nan_set", sticky_flags[7:4], 4'b0010);
    do_op(1, 32'h3F80_0000, 32'hBF80_0000, 2'b00, 2, 1'b0);
    chk("sticky_nan_kept_zero_added", sticky_flags[7:4], 4'b0011);
    chk("sticky_others_untouched", {sticky_flags[15:8], sticky_flags[3:0]}, 0);
    do_op(2, 32'h7FC0_0000, 32'h3F80_0000, 2'b00, 0, 1'b1);
    chk("sticky_clear_wins", sticky_flags, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one combinational `fpu` instance between `NUM_REQ` requesters using round-robin arbitration. Each requester issues an operation with a valid/ready handshake and receives its result and exception flags on a dedicated response handshake. The block registers the operands and holds them on the FPU for `FPU_LAT` cycles before capturing the result, so a registered, timing-friendly FPU port sits between many clients and the shared arithmetic unit.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `FPU_LAT`, default 1: settle cycles between registering the operands and capturing the result, at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_opd1`  in  NUM_REQ*32  packed operand 1; requester i owns bits [32i+31:32i].
- `req_opd2`  in  NUM_REQ*32  packed operand 2.
- `req_op`  in  NUM_REQ*2  packed opcode, passed to `fpu.op` unchanged.
- `rsp_valid`  out  NUM_REQ  one-hot response valid.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_res`  out  32  shared result bus; meaningful only while `rsp_valid` is set.
- `rsp_flags`  out  4  {exp_overflow, exp_underflow, nan, zero}, captured together with `rsp_res`.
- `busy`  out  1  high in EVAL and RESP.

## Operation

- The block instantiates `fpu` internally. Its inputs come only from operand registers, never directly from the request ports.
- Round-robin arbitration:
  - pointer `p` (log2 NUM_REQ bits) resets to 0;
  - the winner is the first i, scanning p, p+1, …, wrapping modulo NUM_REQ, with `req_valid[i]=1`;
  - on acceptance, `p` becomes winner+1, wrapping from NUM_REQ-1 to 0.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - `req_ready[i] = req_valid[i] & (i == winner)`. This is combinational.
  - On acceptance, latch opd1, opd2, op and the grant index, load the counter with FPU_LAT-1, and go to EVAL.
- EVAL:
  - Hold the operand registers.
  - Decrement the counter each cycle. At 0, capture the `fpu` res and flags into the response registers and go to RESP.
- RESP:
  - Drive `rsp_valid[grant]=1` and hold `rsp_res` and `rsp_flags` stable.
  - On `rsp_ready[grant]=1`, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is 0 in EVAL and RESP. Requests pending there wait; they are not queued.
- Requesters hold `req_valid` and operands until accepted. Withdrawing a request before acceptance is legal: arbitration is recomputed every IDLE cycle.
- Reset values: state IDLE, `p`=0, operand registers 0, `rsp_res`=0, `rsp_flags`=0, `rsp_valid`=0, `req_ready`=0, `busy`=0.
- Reset mid-operation aborts the in-flight operation with no response. The pointer returns to 0.

## Timing

- Accept edge to `rsp_valid` rising: FPU_LAT cycles.
- RESP is at least 1 cycle. It is followed by one IDLE cycle before the next accept.
- Minimum issue interval: FPU_LAT+2 cycles.
- With a single requester holding valid, it is re-granted every FPU_LAT+2 cycles.
- With all requesters valid, grants rotate 0,1,2,…,NUM_REQ-1,0.
- If the response stalls with `rsp_ready` low, RESP holds indefinitely and `rsp_res` stays stable.

## Configuration

- Macro: `FPU_ARB_STICKY_FLAGS_EN`.
- Defined:
  - adds input `clr_sticky` (1 bit) and output `sticky_flags` (NUM_REQ*4 bits), reset to 0;
  - on each response handshake, `sticky_flags[4g+3:4g] |= rsp_flags`;
  - `clr_sticky=1` zeroes all sticky flags;
  - when a clear and an OR-update happen in the same cycle, the clear wins.
- Undefined: neither port exists and there are no sticky registers. All other behaviour is identical.

## Test plan

- Reset release with all `req_valid`=0: every output is 0 and `busy`=0 for 10 cycles.
- Requester 2 only, opd1=0x3F800000, opd2=0x40000000, op=2'b00, FPU_LAT=1:
  - `req_ready[2]` goes high in the same cycle;
  - `rsp_valid`=4'b0100 after 1 cycle;
  - `rsp_res` and `rsp_flags` match the standalone `fpu` output for the same inputs.
- All 4 requesters valid continuously with `rsp_ready` tied 1: grant order 0,1,2,3,0,1; each grant is FPU_LAT+2 cycles apart.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid` and `rsp_res` stay stable;
  - no `req_ready` is asserted;
  - `rsp_ready` asserted on a non-granted bit has no effect.
- Assert `rst_n`=0 during EVAL: all outputs are 0 immediately. After release, requester 0 wins first even if the pointer was at 3.
- `FPU_ARB_STICKY_FLAGS_EN`:
  - an operation producing nan sets `sticky_flags` bit 1 of that requester;
  - it stays set across a following zero-result operation;
  - `clr_sticky` in the same cycle as a handshake leaves all sticky flags 0.
